// File: rtl/pwm_pkg.sv
// pwm_pkg: channel mode encodings and default sizes for pwm_gen_mc
package pwm_pkg;
  localparam logic [1:0] MODE_LEFT      = 2'b00;
  localparam logic [1:0] MODE_RIGHT     = 2'b01;
  localparam logic [1:0] MODE_UNALIGNED = 2'b10;
  localparam logic [1:0] MODE_OFF       = 2'b11;
  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 8;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one channel's active compare/mode/polarity registers and registered output
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmp1,
  input  logic [CNT_W-1:0] cmp2,
  input  logic [1:0]       mode,
  input  logic             pol,
  output logic             pwm
);
  logic [CNT_W-1:0] act_cmp1, act_cmp2;
  logic [1:0] act_mode;
  logic act_pol, r;
  always_comb
    r = act_mode == MODE_LEFT      ? cnt < act_cmp1 :
        act_mode == MODE_RIGHT     ? cnt >= act_cmp1 :
        act_mode == MODE_UNALIGNED ? (act_cmp1 <= cnt) && (cnt < act_cmp2) : 1'b0;
  // Output uses the old active set on a load edge; new values apply from the next sample.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_cmp1 <= '0;
      act_cmp2 <= '0;
      act_mode <= '0;
      act_pol  <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      pwm <= en ? r ^ act_pol : act_pol;
      if (load) begin
        act_cmp1 <= cmp1;
        act_cmp2 <= cmp2;
        act_mode <= mode;
        act_pol  <= pol;
      end
    end
endmodule

// File: rtl/pwm_gen_mc.sv
// pwm_gen_mc: multi-channel PWM with shared prescaled counter and period-boundary config reload
module pwm_gen_mc
  import pwm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  upd_lock,
  input  logic [PSC_W-1:0]      psc,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] cmp1,
  input  logic [N_CH*CNT_W-1:0] cmp2,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       pol,
  output logic [N_CH-1:0]       pwm_out,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  upd_evt
);
  logic [CNT_W-1:0] cnt, act_period;
  logic [PSC_W-1:0] psc_cnt, act_psc;
  logic tick, wrap, load;
  always_comb begin
    tick = en && psc_cnt == act_psc;
    wrap = tick && cnt == act_period;
    load = !en || (wrap && !upd_lock);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      psc_cnt    <= '0;
      upd_evt    <= 1'b0;
      act_period <= '0;
      act_psc    <= '0;
    end else begin
      cnt     <= !en || wrap ? '0 : tick ? cnt + 1'b1 : cnt;
      psc_cnt <= !en || tick ? '0 : psc_cnt + 1'b1;
      upd_evt <= wrap;
      if (load) begin
        act_period <= period;
        act_psc    <= psc;
      end
    end
  assign cnt_o = cnt;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_chan #(.CNT_W(CNT_W)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .load (load),
      .cnt  (cnt),
      .cmp1 (cmp1[i*CNT_W +: CNT_W]),
      .cmp2 (cmp2[i*CNT_W +: CNT_W]),
      .mode (mode[2*i +: 2]),
      .pol  (pol[i]),
      .pwm  (pwm_out[i])
    );
  end
endmodule

// File: doc/pwm_gen_mc.md
Name: pwm_gen_mc

Overview:
Multi-channel successor to the single-channel PWM generator.
- Owns its own prescaled up-counter; no external count_val.
- Drives N channels from that shared time base, each with its own compare values, mode and polarity.
- All configuration is double-buffered: input buses act as shadow registers, copied to active registers only at a period boundary, so output waveforms never glitch mid-period.
- Sits between the register file (config buses) and the top-level pins.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CNT_W, 16, counter/period/compare width
PSC_W, 8, prescaler width

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  global enable
upd_lock  input  1  1 = block shadow-to-active reload at period boundary
psc  input  PSC_W  prescaler; counter ticks every psc+1 clk cycles
period  input  CNT_W  counter counts 0..period inclusive
cmp1  input  N_CH*CNT_W  per-channel compare 1, channel i at [i*CNT_W +: CNT_W]
cmp2  input  N_CH*CNT_W  per-channel compare 2 (unaligned mode only)
mode  input  2*N_CH  per-channel mode, channel i at [2i +: 2]
pol  input  N_CH  per-channel polarity, 1 = inverted
pwm_out  output  N_CH  PWM outputs
cnt_o  output  CNT_W  current counter value
upd_evt  output  1  one-cycle pulse at each period wrap

Behaviour:
- Reset (rst_n low, async):
  - cnt_o=0, prescaler count=0, upd_evt=0.
  - All active registers 0.
  - pwm_out = 0 (not polarity-adjusted; pol not yet loaded).
- en=0:
  - cnt and prescaler count forced to 0; upd_evt=0.
  - Active registers reload from inputs every cycle.
  - pwm_out[i] <= active pol[i] (inactive level).
- en=1:
  - Prescaler counts 0..psc; tick asserted in the cycle prescaler count == psc, then prescaler count returns to 0. psc=0 gives a tick every cycle.
  - On tick with cnt<period: cnt increments.
  - On tick with cnt==period (wrap): cnt <= 0; upd_evt <= 1 for one cycle; if upd_lock=0, all active registers (period, psc, cmp1, cmp2, mode, pol) load from inputs in the same edge.
  - If upd_lock=1 at the wrap, active registers are kept and the reload is lost for that period; there is no pending flag.
  - period=0: cnt stays 0 and a wrap occurs on every tick.
- Channel function. Raw level r is evaluated on current cnt and active registers:
  - mode 00, left-aligned: r = (cnt < cmp1). cmp1=0 gives always low; cmp1>period gives always high.
  - mode 01, right-aligned: r = (cnt >= cmp1). cmp1=0 gives always high; cmp1>period gives always low.
  - mode 10, unaligned: r = (cmp1 <= cnt) && (cnt < cmp2). cmp2<=cmp1 gives always low.
  - mode 11, off: r = 0.
  - pwm_out[i] <= r ^ pol[i]. The output is registered, so pwm_out lags cnt_o by exactly 1 clk.
- Wrap cycle evaluation: the wrap edge loads new active values and cnt=0 together. The following edge evaluates cnt=0 with the new configuration, so the first sample of a new period always uses new values.
- Arithmetic: all comparisons are unsigned CNT_W; no saturation; cnt never exceeds active period.
- Mid-operation changes:
  - Input changes while en=1 do not affect outputs until the next unlocked wrap.
  - en falling: next edge applies the en=0 rules.
  - en rising: counting starts from cnt=0 with the values loaded while disabled.
  - rst_n mid-period: immediate return to reset values; no completion of the period.

Decomposition:
- Package pwm_pkg:
  - mode constants MODE_LEFT=2'b00, MODE_RIGHT=2'b01, MODE_UNALIGNED=2'b10, MODE_OFF=2'b11
  - default parameter values
- Sub-module pwm_chan, instantiated N_CH times via generate:
  - holds one channel's active cmp1/cmp2/mode/pol registers and its compare logic
  - drives the registered output bit
  - inputs: cnt, load strobe, en
- Counter, prescaler and upd_evt live in the top module.

Test Plan:
- N_CH=4, psc=0, period=9; ch0 mode00 cmp1=3; ch1 mode01 cmp1=3; ch2 mode10 cmp1=2 cmp2=6; ch3 mode11; pol=0; en=1 -> per 10-cycle period:
  - ch0 high 3 cycles, ch1 high 7, ch2 high 4, ch3 always 0
  - upd_evt pulses every 10 clk
  - pwm_out lags cnt_o by 1 clk
- psc=2, period=4 -> cnt_o changes every 3 clk; upd_evt every 15 clk.
- Change ch0 cmp1 from 3 to 7 at cnt=5 with upd_lock=0 -> duty unchanged for the rest of the period; new duty 7/10 from the next cnt=0 sample.
- Same change with upd_lock=1 across 2 wraps, then release -> old duty for 2 periods; new duty starts after the first wrap following release.
- Boundaries, period=9:
  - mode00 cmp1=0 -> constant 0
  - mode00 cmp1=12 -> constant 1
  - mode10 cmp1=6 cmp2=2 -> constant 0
  - pol=1 -> all inverted
  - period=0 -> upd_evt every tick
- Assert rst_n low at cnt=5 -> all outputs 0 asynchronously. Deassert with en=1 -> counting restarts from 0. With en=0 and pol=4'b1010 -> pwm_out=4'b1010.
